// File: rtl/fuzz_sig_pkg.sv
// Shared types and helpers for the fuzz signature collector: FSM states,
// default SEED/POLY constants and the input-folding function.
package fuzz_sig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          DW_DEF    = 82;
  localparam int          SIG_W_DEF = 32;
  localparam logic [31:0] SEED_DEF  = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY_DEF  = 32'h04C1_1DB7;

  // Upper bounds for the generic fold; DW and SIG_W must not exceed them.
  localparam int FOLD_DW_MAX  = 256;
  localparam int FOLD_SIG_MAX = 64;

  // XOR all SIG_W-wide chunks of a zero-padded vector into bits [sig_w-1:0].
  function automatic logic [FOLD_SIG_MAX-1:0] fold(input logic [FOLD_DW_MAX-1:0] d,
                                                   input int unsigned            sig_w);
    logic [FOLD_SIG_MAX-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FOLD_DW_MAX; i++) begin
      r[i % sig_w] = r[i % sig_w] ^ d[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fuzz_sig_misr.sv
// Combinational MISR step: shift left, conditional polynomial feedback,
// XOR in the folded sample; passes sig through when en is low.
module fuzz_sig_misr
  import fuzz_sig_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = POLY_DEF
) (
  input  logic [SIG_W-1:0] sig,
  input  logic [SIG_W-1:0] fold_in,
  input  logic             en,
  output logic [SIG_W-1:0] sig_next
);

  always_comb begin
    sig_next = sig;
    if (en) begin
      sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold_in;
    end
  end

endmodule

// File: rtl/fuzz_sig_collector.sv
// Absorbs NSAMP valid samples of the fuzz DUT result into a MISR signature and
// offers it on a valid/ready port. Optional toggle coverage via FUZZ_SIG_COV_EN.
module fuzz_sig_collector
  import fuzz_sig_pkg::*;
#(
  parameter int               DW    = DW_DEF,
  parameter int               SIG_W = SIG_W_DEF,
  parameter int               NSAMP = 256,
  parameter logic [SIG_W-1:0] SEED  = SEED_DEF,
  parameter logic [SIG_W-1:0] POLY  = POLY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             busy,
  output logic             drop,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [SIG_W-1:0] sig_data
`ifdef FUZZ_SIG_COV_EN
  ,
  output logic [DW-1:0]    sig_cov
`endif
);

  localparam int             CNT_W = $clog2(NSAMP + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSAMP - 1);

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;

  logic                    absorb;
  logic [FOLD_SIG_MAX-1:0] fold_full;
  logic [SIG_W-1:0]        fold_v;
  logic [SIG_W-1:0]        misr_next;
  logic                    unused_fold;

  assign absorb      = (state_q == RUN) && in_valid;
  assign fold_full   = fold(FOLD_DW_MAX'(in_data), SIG_W);
  assign fold_v      = fold_full[SIG_W-1:0];
  assign unused_fold = ^fold_full;

  fuzz_sig_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .sig      (sig_q),
    .fold_in  (fold_v),
    .en       (absorb),
    .sig_next (misr_next)
  );

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    drop_d  = in_valid && (state_q != RUN);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sig_d   = SEED;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (in_valid) begin
          sig_d = misr_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (sig_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign sig_valid = (state_q == DONE);
  assign drop      = drop_q;
  assign sig_data  = sig_q;

`ifdef FUZZ_SIG_COV_EN
  logic [DW-1:0] cov_q, cov_d;
  logic [DW-1:0] prev_q, prev_d;

  // The first sample of a run (cnt==0) only seeds prev; it has nothing to toggle against.
  always_comb begin
    cov_d  = cov_q;
    prev_d = prev_q;
    if ((state_q == IDLE) && start) begin
      cov_d  = '0;
      prev_d = '0;
    end else if (absorb) begin
      prev_d = in_data;
      if (cnt_q != '0) begin
        cov_d = cov_q | (in_data ^ prev_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cov_q  <= '0;
      prev_q <= '0;
    end else begin
      cov_q  <= cov_d;
      prev_q <= prev_d;
    end
  end

  assign sig_cov = cov_q;
`endif

endmodule

// File: tb/tb_fuzz_sig_collector.sv
// Directed self-checking bench for fuzz_sig_collector; three instances cover
// NSAMP = 1, 4 and 256 on shared data/handshake inputs.
module tb_fuzz_sig_collector;

  localparam logic [31:0] SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start1 = 1'b0, start4 = 1'b0, start256 = 1'b0;
  logic        in_valid = 1'b0;
  logic [81:0] in_data = '0;
  logic        sig_ready = 1'b0;

  logic        busy1, drop1, sig_valid1;
  logic        busy4, drop4, sig_valid4;
  logic        busy256, drop256, sig_valid256;
  logic [31:0] sig_data1, sig_data4, sig_data256;
`ifdef FUZZ_SIG_COV_EN
  logic [81:0] sig_cov1, sig_cov4, sig_cov256;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fuzz_sig_collector #(.NSAMP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .in_data(in_data),
    .busy(busy1), .drop(drop1), .sig_valid(sig_valid1), .sig_ready(sig_ready),
    .sig_data(sig_data1)
`ifdef FUZZ_SIG_COV_EN
    , .sig_cov(sig_cov1)
`endif
  );

  fuzz_sig_collector #(.NSAMP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid), .in_data(in_data),
    .busy(busy4), .drop(drop4), .sig_valid(sig_valid4), .sig_ready(sig_ready),
    .sig_data(sig_data4)
`ifdef FUZZ_SIG_COV_EN
    , .sig_cov(sig_cov4)
`endif
  );

  fuzz_sig_collector #(.NSAMP(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start256), .in_valid(in_valid), .in_data(in_data),
    .busy(busy256), .drop(drop256), .sig_valid(sig_valid256), .sig_ready(sig_ready),
    .sig_data(sig_data256)
`ifdef FUZZ_SIG_COV_EN
    , .sig_cov(sig_cov256)
`endif
  );

  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [81:0] d);
    logic [31:0] f;
    f = d[31:0] ^ d[63:32] ^ {14'b0, d[81:64]};
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    checks++; if (sig_valid1 !== 1'b0) begin errors++; $display("FAIL reset_sig_valid: got %b expected 0", sig_valid1); end
    checks++; if (drop1 !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", drop1); end
    checks++; if (sig_data1 !== SEED) begin errors++; $display("FAIL reset_sig_data: got %h expected %h", sig_data1, SEED); end
`ifdef FUZZ_SIG_COV_EN
    checks++; if (sig_cov1 !== 82'h0) begin errors++; $display("FAIL reset_sig_cov: got %h expected 0", sig_cov1); end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy1); end
    $display("txn reset done");
  endtask

  task automatic test_nsamp1_zero();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL n1_busy: got %b expected 1", busy1); end
    in_valid = 1'b1;
    in_data  = 82'h0;
    tick();
    in_valid = 1'b0;
    checks++; if (sig_valid1 !== 1'b1) begin errors++; $display("FAIL n1_sig_valid: got %b expected 1", sig_valid1); end
    checks++; if (sig_data1 !== 32'hFB3E_E249) begin errors++; $display("FAIL n1_sig_data: got %h expected FB3EE249", sig_data1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL n1_busy_done: got %b expected 0", busy1); end
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
    checks++; if (sig_valid1 !== 1'b0) begin errors++; $display("FAIL n1_handshake: got %b expected 0", sig_valid1); end
    $display("txn nsamp1 data=0 sig=%h", sig_data1);
  endtask

  task automatic test_fold();
    logic [81:0] vecs[2];
    vecs[0] = 82'h1;
    vecs[1] = 82'h1 << 64;
    for (int k = 0; k < 2; k++) begin
      start1 = 1'b1;
      tick();
      start1   = 1'b0;
      in_valid = 1'b1;
      in_data  = vecs[k];
      tick();
      in_valid = 1'b0;
      checks++; if (sig_valid1 !== 1'b1) begin errors++; $display("FAIL fold_valid[%0d]: got %b expected 1", k, sig_valid1); end
      checks++; if (sig_data1 !== 32'hFB3E_E248) begin errors++; $display("FAIL fold_sig[%0d]: got %h expected FB3EE248", k, sig_data1); end
      $display("txn fold data=%h sig=%h", vecs[k], sig_data1);
      sig_ready = 1'b1;
      tick();
      sig_ready = 1'b0;
    end
  endtask

  task automatic test_gaps();
    logic [81:0] d4[4];
    int          pat[7];
    int          nv;
    logic [31:0] e, gap_sig;
    logic        exp_v;
    d4[0] = 82'h1_2345_6789_ABCD_EF01_2345;
    d4[1] = 82'h2_0000_0000_0000_0000_0001;
    d4[2] = 82'h0_FFFF_FFFF_0000_0000_00FF;
    d4[3] = 82'h3_DEAD_BEEF_CAFE_F00D_1234;
    pat = '{1, 0, 0, 1, 1, 0, 1};
    e = SEED;
    for (int i = 0; i < 4; i++) e = model_step(e, d4[i]);

    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    nv = 0;
    for (int j = 0; j < 7; j++) begin
      in_valid = (pat[j] != 0);
      in_data  = (pat[j] != 0) ? d4[nv] : 82'h3_FFFF_FFFF_FFFF_FFFF_FFFF;
      if (pat[j] != 0) nv++;
      tick();
      exp_v = (nv == 4);
      checks++; if (sig_valid4 !== exp_v) begin errors++; $display("FAIL gap_valid[%0d]: got %b expected %b", j, sig_valid4, exp_v); end
    end
    in_valid = 1'b0;
    checks++; if (sig_data4 !== e) begin errors++; $display("FAIL gap_sig: got %h expected %h", sig_data4, e); end
    gap_sig = sig_data4;
    $display("txn nsamp4 gapped sig=%h", sig_data4);
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;

    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = d4[i];
      tick();
    end
    in_valid = 1'b0;
    checks++; if (sig_valid4 !== 1'b1) begin errors++; $display("FAIL nogap_valid: got %b expected 1", sig_valid4); end
    checks++; if (sig_data4 !== gap_sig) begin errors++; $display("FAIL nogap_vs_gap: got %h expected %h", sig_data4, gap_sig); end
    $display("txn nsamp4 gapless sig=%h", sig_data4);
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
  endtask

  task automatic test_done_hold();
    start1 = 1'b1;
    tick();
    start1   = 1'b0;
    in_valid = 1'b1;
    in_data  = 82'h5;
    tick();
    in_valid = 1'b1;
    start1   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (sig_valid1 !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b expected 1", c, sig_valid1); end
      checks++; if (sig_data1 !== 32'hFB3E_E24C) begin errors++; $display("FAIL hold_sig[%0d]: got %h expected FB3EE24C", c, sig_data1); end
      checks++; if (drop1 !== 1'b1) begin errors++; $display("FAIL hold_drop[%0d]: got %b expected 1", c, drop1); end
    end
    sig_ready = 1'b1;
    tick();
    checks++; if (sig_valid1 !== 1'b0) begin errors++; $display("FAIL hold_handshake: got %b expected 0", sig_valid1); end
    start1    = 1'b0;
    sig_ready = 1'b0;
    in_valid  = 1'b0;
    tick();
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL hold_start_ignored: got %b expected 0", busy1); end
    checks++; if (drop1 !== 1'b0) begin errors++; $display("FAIL hold_drop_clear: got %b expected 0", drop1); end
    $display("txn done_hold sig=%h", sig_data1);
  endtask

  task automatic test_reset_midrun();
    logic [31:0] e;
    start256 = 1'b1;
    tick();
    start256 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 82'(i) ^ (82'(i) << 40);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (busy256 !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy256); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy256 !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy256); end
    checks++; if (sig_data256 !== SEED) begin errors++; $display("FAIL mid_rst_sig: got %h expected %h", sig_data256, SEED); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++; if (busy256 !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b expected 0", busy256); end

    e = SEED;
    start256 = 1'b1;
    tick();
    start256 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = (82'(i) << 60) | 82'(255 - i);
      e = model_step(e, in_data);
      tick();
      if (i == 254) begin
        checks++; if (sig_valid256 !== 1'b0) begin errors++; $display("FAIL n256_early: got %b expected 0", sig_valid256); end
      end
    end
    in_valid = 1'b0;
    checks++; if (sig_valid256 !== 1'b1) begin errors++; $display("FAIL n256_valid: got %b expected 1", sig_valid256); end
    checks++; if (sig_data256 !== e) begin errors++; $display("FAIL n256_sig: got %h expected %h", sig_data256, e); end
    $display("txn nsamp256 after reset sig=%h", sig_data256);
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
  endtask

`ifdef FUZZ_SIG_COV_EN
  task automatic test_cov();
    logic [81:0] cv[4];
    cv[0] = 82'h0;
    cv[1] = 82'h3;
    cv[2] = 82'h1;
    cv[3] = 82'h1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = cv[i];
      tick();
      if (i == 2) begin
        checks++; if (sig_cov4 !== 82'h3) begin errors++; $display("FAIL cov_three: got %h expected 3", sig_cov4); end
      end
    end
    in_valid = 1'b0;
    checks++; if (sig_cov4 !== 82'h3) begin errors++; $display("FAIL cov_done: got %h expected 3", sig_cov4); end
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checks++; if (sig_cov4 !== 82'h0) begin errors++; $display("FAIL cov_clear: got %h expected 0", sig_cov4); end
    $display("txn coverage map checked");
  endtask
`endif

  initial begin
    test_reset();
    test_nsamp1_zero();
    test_fold();
    test_gaps();
    test_done_hold();
    test_reset_midrun();
`ifdef FUZZ_SIG_COV_EN
    test_cov();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
